coherency_req_scheduler: RTL

Shares the single L2 cache coherency controller among NUM_CORES L1 requesters. Every cycle it picks at most one pending coherency request using round-robin arbitration with a starvation override. It blocks any request whose cache line already has a transaction in flight, and tracks up to MAX_OUTSTANDING in-flight transactions in a slot table. It sits between the L1 coherency request ports and the coherency controller's request/completion port.

---
 rtl/coherency_req_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/coherency_req_scheduler.sv
// Feeds L1 coherency requests, one at a time, to the shared L2 coherency controller.
// Arbitration is round-robin with a starvation override. Same-line requests are held back while a transaction on that line is in flight.
//
// state | meaning
// IDLE  | looking for an eligible core; grant and slot allocation happen here
// ISSUE | granted request held on the controller port until ctrl_req_ready_i
module coherency_req_scheduler #(
   parameter int NUM_CORES        = 4,
   parameter int ADDR_WIDTH       = 32,
   parameter int LINE_OFFSET_BITS = 6,
   parameter int MAX_OUTSTANDING  = 2,
   parameter int STARVE_LIMIT     = 15,
   localparam int CORE_W = $clog2(NUM_CORES),
   localparam int SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
   localparam int OCC_W  = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NUM_CORES-1:0]            req_valid_i,
   output logic [NUM_CORES-1:0]            req_ready_o,
   input  logic [NUM_CORES*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_CORES*2-1:0]          req_type_i,
   output logic                            ctrl_req_valid_o,
   input  logic                            ctrl_req_ready_i,
   output logic [ADDR_WIDTH-1:0]           ctrl_req_addr_o,
   output logic [1:0]                      ctrl_req_type_o,
   output logic [CORE_W-1:0]               ctrl_req_core_o,
   output logic [SLOT_W-1:0]               ctrl_req_slot_o,
   input  logic                            ctrl_done_valid_i,
   input  logic [SLOT_W-1:0]               ctrl_done_slot_i,
   output logic [OCC_W-1:0]                occupancy_o,
   output logic                            err_o
);
   localparam int LINE_W = ADDR_WIDTH - LINE_OFFSET_BITS;
   localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic {IDLE, ISSUE} state_e;
   state_e state_q, state_d;

   logic [MAX_OUTSTANDING-1:0] slot_valid_q, slot_valid_d;
   logic [LINE_W-1:0]          slot_line_q [MAX_OUTSTANDING];
   logic [CORE_W-1:0]          slot_core_q [MAX_OUTSTANDING];
   logic [CNT_W-1:0]           starve_q [NUM_CORES];
   logic [CORE_W-1:0]          rr_ptr_q;
   logic [ADDR_WIDTH-1:0]      addr_q;
   logic [1:0]                 type_q;
   logic [SLOT_W-1:0]          slot_q;
   logic [OCC_W-1:0]           occ_q, occ_d;
   logic                       err_q;

   logic [LINE_W-1:0]    req_line [NUM_CORES];
   logic [NUM_CORES-1:0] eligible;
   logic                 free_any;
   logic [SLOT_W-1:0]    free_idx;
   logic [CORE_W-1:0]    winner;
   logic                 grant;
   logic                 done_hit;
   logic                 done_err;

   // Eligibility looks only at registered slot state, so a done frees its line a cycle later.
   always_comb begin : eligibility
      free_any = 1'b0;
      free_idx = '0;
      for (int s = MAX_OUTSTANDING - 1; s >= 0; s--) begin
         if (!slot_valid_q[s]) begin
            free_any = 1'b1;
            free_idx = SLOT_W'(s);
         end
      end
      eligible = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         req_line[i] = req_addr_i[i*ADDR_WIDTH + LINE_OFFSET_BITS +: LINE_W];
         eligible[i] = req_valid_i[i] && free_any;
         for (int s = 0; s < MAX_OUTSTANDING; s++) begin
            if (slot_valid_q[s] && (slot_line_q[s] == req_line[i])) eligible[i] = 1'b0;
         end
      end
   end

   always_comb begin : pick_winner
      winner = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         if (eligible[(int'(rr_ptr_q) + k) % NUM_CORES])
            winner = CORE_W'((int'(rr_ptr_q) + k) % NUM_CORES);
      end
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (eligible[i] && (starve_q[i] == STARVE_MAX)) winner = CORE_W'(i);
      end
   end

   always_comb begin : fsm_next
      state_d     = state_q;
      grant       = 1'b0;
      req_ready_o = '0;
      unique case (state_q)
         IDLE: begin
            if (|eligible) begin
               grant               = 1'b1;
               req_ready_o[winner] = 1'b1;
               state_d             = ISSUE;
            end
         end
         ISSUE: begin
            if (ctrl_req_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin : slot_next
      done_hit = ctrl_done_valid_i
                 && ({1'b0, ctrl_done_slot_i} < (SLOT_W + 1)'(MAX_OUTSTANDING))
                 && slot_valid_q[ctrl_done_slot_i];
      done_err = ctrl_done_valid_i && !done_hit;
      slot_valid_d = slot_valid_q;
      if (done_hit) slot_valid_d[ctrl_done_slot_i] = 1'b0;
      if (grant)    slot_valid_d[free_idx] = 1'b1;
      occ_d = '0;
      for (int s = 0; s < MAX_OUTSTANDING; s++) occ_d = occ_d + OCC_W'(slot_valid_d[s]);
   end

   always_ff @(posedge clk_i) begin : fsm_reg
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin : datapath
      if (!rst_ni) begin
         slot_valid_q <= '0;
         occ_q        <= '0;
         err_q        <= 1'b0;
         rr_ptr_q     <= '0;
         addr_q       <= '0;
         type_q       <= '0;
         slot_q       <= '0;
         for (int s = 0; s < MAX_OUTSTANDING; s++) begin
            slot_line_q[s] <= '0;
            slot_core_q[s] <= '0;
         end
         for (int i = 0; i < NUM_CORES; i++) starve_q[i] <= '0;
      end else begin
         slot_valid_q <= slot_valid_d;
         occ_q        <= occ_d;
         if (done_err) err_q <= 1'b1;
         if (grant) begin
            slot_line_q[free_idx] <= req_line[winner];
            slot_core_q[free_idx] <= winner;
            rr_ptr_q <= (winner == CORE_W'(NUM_CORES - 1)) ? '0 : winner + CORE_W'(1);
            addr_q   <= req_addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            type_q   <= req_type_i[int'(winner)*2 +: 2];
            slot_q   <= free_idx;
         end
         for (int i = 0; i < NUM_CORES; i++) begin
            if (!req_valid_i[i] || (grant && (winner == CORE_W'(i))))
               starve_q[i] <= '0;
            else if (starve_q[i] != STARVE_MAX)
               starve_q[i] <= starve_q[i] + CORE_W'(0) + CNT_W'(1);
         end
      end
   end

   // The slot entry and slot_q are written on the same edge, so the table doubles as the core-id register.
   assign ctrl_req_valid_o = (state_q == ISSUE);
   assign ctrl_req_addr_o  = addr_q;
   assign ctrl_req_type_o  = type_q;
   assign ctrl_req_slot_o  = slot_q;
   assign ctrl_req_core_o  = slot_core_q[slot_q];
   assign occupancy_o      = occ_q;
   assign err_o            = err_q;

endmodule
